// File: rtl/isa_pkg.sv
// Instruction-set definitions shared by the encoder and the control-unit decoder:
// op ids, 6-bit opcodes, word field positions and op classification.
package isa_pkg;

    typedef enum logic [4:0] {
        OP_NOP  = 5'd0,
        OP_ADD  = 5'd1,
        OP_SUB  = 5'd2,
        OP_AND  = 5'd3,
        OP_OR   = 5'd4,
        OP_NOR  = 5'd5,
        OP_XOR  = 5'd6,
        OP_SLA  = 5'd7,
        OP_SLL  = 5'd8,
        OP_SRA  = 5'd9,
        OP_SRL  = 5'd10,
        OP_SWP  = 5'd11,
        OP_ADDI = 5'd12,
        OP_SUBI = 5'd13,
        OP_LD   = 5'd14,
        OP_ST   = 5'd15,
        OP_BEZ  = 5'd16,
        OP_BNE  = 5'd17,
        OP_JMP  = 5'd18,
        OP_MOV  = 5'd19,
        OP_XSWP = 5'd20
    } op_id_e;

    typedef enum logic [1:0] {
        FMT_NONE = 2'd0,
        FMT_R    = 2'd1,
        FMT_I    = 2'd2
    } fmt_e;

    localparam logic [5:0] OPC_NOP  = 6'b000000;
    localparam logic [5:0] OPC_ADD  = 6'b000001;
    localparam logic [5:0] OPC_SUB  = 6'b000011;
    localparam logic [5:0] OPC_AND  = 6'b000101;
    localparam logic [5:0] OPC_OR   = 6'b000110;
    localparam logic [5:0] OPC_NOR  = 6'b000111;
    localparam logic [5:0] OPC_XOR  = 6'b001000;
    localparam logic [5:0] OPC_SLA  = 6'b001001;
    localparam logic [5:0] OPC_SLL  = 6'b001010;
    localparam logic [5:0] OPC_SRA  = 6'b001011;
    localparam logic [5:0] OPC_SRL  = 6'b001100;
    localparam logic [5:0] OPC_SWP  = 6'b111111;
    localparam logic [5:0] OPC_ADDI = 6'b100000;
    localparam logic [5:0] OPC_SUBI = 6'b100001;
    localparam logic [5:0] OPC_LD   = 6'b100100;
    localparam logic [5:0] OPC_ST   = 6'b100101;
    localparam logic [5:0] OPC_BEZ  = 6'b101000;
    localparam logic [5:0] OPC_BNE  = 6'b101001;
    localparam logic [5:0] OPC_JMP  = 6'b101010;

    localparam int OPC_LSB  = 26;
    localparam int DEST_LSB = 21;
    localparam int SRC1_LSB = 16;
    localparam int SRC2_LSB = 11;
    localparam int IMM_LSB  = 0;

    // Pseudo-ops classify by the format of the words they expand into.
    function automatic fmt_e op_format(logic [4:0] op);
        case (op)
            OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR, OP_XOR,
            OP_SLA, OP_SLL, OP_SRA, OP_SRL, OP_SWP, OP_XSWP:
                return FMT_R;
            OP_ADDI, OP_SUBI, OP_LD, OP_ST, OP_BEZ, OP_BNE, OP_JMP, OP_MOV:
                return FMT_I;
            default:
                return FMT_NONE;
        endcase
    endfunction

    function automatic logic [5:0] opcode_of(logic [4:0] op);
        case (op)
            OP_ADD:  return OPC_ADD;
            OP_SUB:  return OPC_SUB;
            OP_AND:  return OPC_AND;
            OP_OR:   return OPC_OR;
            OP_NOR:  return OPC_NOR;
            OP_XOR:  return OPC_XOR;
            OP_SLA:  return OPC_SLA;
            OP_SLL:  return OPC_SLL;
            OP_SRA:  return OPC_SRA;
            OP_SRL:  return OPC_SRL;
            OP_SWP:  return OPC_SWP;
            OP_ADDI: return OPC_ADDI;
            OP_SUBI: return OPC_SUBI;
            OP_LD:   return OPC_LD;
            OP_ST:   return OPC_ST;
            OP_BEZ:  return OPC_BEZ;
            OP_BNE:  return OPC_BNE;
            OP_JMP:  return OPC_JMP;
            OP_MOV:  return OPC_ADDI;
            OP_XSWP: return OPC_XOR;
            default: return OPC_NOP;
        endcase
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Request and output-word handshake bundle between the loader front end,
// the instruction encoder and the instruction-memory writer.
interface instr_encoder_if #(
    parameter int ADDR_W = 10
);
    logic              req_valid;
    logic              req_ready;
    logic [4:0]        req_op;
    logic [4:0]        req_dest;
    logic [4:0]        req_src1;
    logic [4:0]        req_src2;
    logic [15:0]       req_imm;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [31:0]       out_word;

    modport master (
        output req_valid, req_op, req_dest, req_src1, req_src2, req_imm, out_ready,
        input  req_ready, out_valid, out_addr, out_word
    );

    modport slave (
        input  req_valid, req_op, req_dest, req_src1, req_src2, req_imm, out_ready,
        output req_ready, out_valid, out_addr, out_word
    );
endinterface

// File: rtl/instr_word_pack.sv
// Combinational packer: op id, register fields and expansion step to one
// 32-bit instruction word, plus a flag saying the op id is known.
module instr_word_pack
    import isa_pkg::*;
(
    input  logic [4:0]  op,
    input  logic [4:0]  dest,
    input  logic [4:0]  src1,
    input  logic [4:0]  src2,
    input  logic [15:0] imm,
    input  logic [1:0]  step,
    output logic [31:0] word,
    output logic        op_ok
);
    fmt_e        fmt;
    logic [4:0]  f_dest;
    logic [4:0]  f_src1;
    logic [4:0]  f_src2;
    logic [15:0] f_imm;

    always_comb begin
        fmt    = op_format(op);
        f_dest = dest;
        f_src1 = src1;
        f_src2 = src2;
        f_imm  = imm;

        if (op == OP_MOV) begin
            f_imm = '0;
        end

        // XOR swap: steps 0 and 2 are d^=s, step 1 is s^=d.
        if (op == OP_XSWP) begin
            if (step == 2'd1) begin
                f_dest = src1;
                f_src1 = src1;
                f_src2 = dest;
            end else begin
                f_dest = dest;
                f_src1 = dest;
                f_src2 = src1;
            end
        end

        word = '0;
        word[OPC_LSB +: 6]  = opcode_of(op);
        word[DEST_LSB +: 5] = f_dest;
        word[SRC1_LSB +: 5] = f_src1;
        case (fmt)
            FMT_R:   word[SRC2_LSB +: 5] = f_src2;
            FMT_I:   word[IMM_LSB +: 16] = f_imm;
            default: word = '0;
        endcase

        if (op == OP_NOP) begin
            word = '0;
        end

        op_ok = (fmt != FMT_NONE);
    end
endmodule

// File: rtl/instr_encoder.sv
// Streaming instruction encoder: accepts micro-op requests, emits encoded
// address/word pairs, expanding XSWP into three words.
//
//   state | meaning
//   IDLE  | no word held
//   HOLD  | word held, nothing left to expand
//   EXP   | word held, exp_left (1 or 2) expansion words still to load
module instr_encoder
    import isa_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic           clk,
    input  logic           rst,
    instr_encoder_if.slave bus,
    output logic           err,
    output logic           wrapped
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_EXP  = 2'd2
    } state_e;

    state_e            state;
    logic [1:0]        exp_left;
    logic              out_valid;
    logic [31:0]       out_word;
    logic [ADDR_W-1:0] out_addr;
    logic [4:0]        xs_dest;
    logic [4:0]        xs_src;

    logic              req_ready;
    logic              accept;
    logic              out_fire;
    logic              multi;
    logic [4:0]        pk_op;
    logic [4:0]        pk_dest;
    logic [4:0]        pk_src1;
    logic [1:0]        pk_step;
    logic [31:0]       pk_word;
    logic              pk_ok;

    assign req_ready = !out_valid || (bus.out_ready && (state == ST_HOLD));
    assign accept    = bus.req_valid && req_ready;
    assign out_fire  = out_valid && bus.out_ready;
    assign multi     = (bus.req_op == OP_XSWP);

    assign bus.req_ready = req_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_word  = out_word;
    assign bus.out_addr  = out_addr;

    // During expansion the packer is fed the saved XSWP operands, not the request.
    always_comb begin
        pk_op   = bus.req_op;
        pk_dest = bus.req_dest;
        pk_src1 = bus.req_src1;
        pk_step = 2'd0;
        if (state == ST_EXP) begin
            pk_op   = OP_XSWP;
            pk_dest = xs_dest;
            pk_src1 = xs_src;
            pk_step = (exp_left == 2'd2) ? 2'd1 : 2'd2;
        end
    end

    instr_word_pack u_pack (
        .op    (pk_op),
        .dest  (pk_dest),
        .src1  (pk_src1),
        .src2  (bus.req_src2),
        .imm   (bus.req_imm),
        .step  (pk_step),
        .word  (pk_word),
        .op_ok (pk_ok)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            exp_left  <= 2'd0;
            out_valid <= 1'b0;
            out_word  <= '0;
            out_addr  <= ADDR_W'(BASE_ADDR);
            err       <= 1'b0;
            wrapped   <= 1'b0;
            xs_dest   <= '0;
            xs_src    <= '0;
        end else begin
            if (out_fire) begin
                out_addr <= out_addr + ADDR_W'(1);
                if (&out_addr) begin
                    wrapped <= 1'b1;
                end
            end

            if (accept && !pk_ok) begin
                err <= 1'b1;
            end

            case (state)
                ST_EXP: begin
                    if (out_fire) begin
                        out_word <= pk_word;
                        exp_left <= exp_left - 2'd1;
                        if (exp_left == 2'd1) begin
                            state <= ST_HOLD;
                        end
                    end
                end
                default: begin
                    // An accept in HOLD always coincides with an out handshake.
                    if (accept && pk_ok) begin
                        out_word  <= pk_word;
                        out_valid <= 1'b1;
                        if (multi) begin
                            state    <= ST_EXP;
                            exp_left <= 2'd2;
                            xs_dest  <= bus.req_dest;
                            xs_src   <= bus.req_src1;
                        end else begin
                            state    <= ST_HOLD;
                            exp_left <= 2'd0;
                        end
                    end else if (out_fire) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed cases plus random traffic against a
// word-queue reference model; a 2-bit-address twin shares the stimulus.
module tb_instr_encoder;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic err, wrapped, err_w, wrapped_w;

    int total = 0;
    int bad   = 0;

    logic [31:0] q[$];
    int          m_addr;
    int          m_hs;
    bit          m_err;

    int opc_tab [0:18] = '{0, 1, 3, 5, 6, 7, 8, 9, 10, 11, 12, 63,
                           32, 33, 36, 37, 40, 41, 42};

    instr_encoder_if #(.ADDR_W(10)) b ();
    instr_encoder_if #(.ADDR_W(2))  bw ();

    assign bw.req_valid = b.req_valid;
    assign bw.req_op    = b.req_op;
    assign bw.req_dest  = b.req_dest;
    assign bw.req_src1  = b.req_src1;
    assign bw.req_src2  = b.req_src2;
    assign bw.req_imm   = b.req_imm;
    assign bw.out_ready = b.out_ready;

    instr_encoder #(.ADDR_W(10), .BASE_ADDR(0)) dut (
        .clk(clk), .rst(rst), .bus(b), .err(err), .wrapped(wrapped)
    );

    instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut_w (
        .clk(clk), .rst(rst), .bus(bw), .err(err_w), .wrapped(wrapped_w)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rw(input int opc, input int d, input int s1, input int s2);
        return (32'(opc) << 26) | (32'(d) << 21) | (32'(s1) << 16) | (32'(s2) << 11);
    endfunction

    function automatic logic [31:0] iw(input int opc, input int d, input int s1, input int imm);
        return (32'(opc) << 26) | (32'(d) << 21) | (32'(s1) << 16) | 32'(imm);
    endfunction

    function automatic void push_expected(input int op, input int d, input int s1,
                                          input int s2, input int imm);
        if (op == 0)       q.push_back(32'h0);
        else if (op <= 11) q.push_back(rw(opc_tab[op], d, s1, s2));
        else if (op <= 18) q.push_back(iw(opc_tab[op], d, s1, imm));
        else if (op == 19) q.push_back(iw(32, d, s1, 0));
        else begin
            q.push_back(rw(8, d, d, s1));
            q.push_back(rw(8, s1, s1, d));
            q.push_back(rw(8, d, d, s1));
        end
    endfunction

    // Entered and left at posedge+1; drives one cycle and checks it.
    task automatic cycle(input bit v, input int op, input int d, input int s1,
                         input int s2, input int imm, input bit ordy);
        bit exp_rdy, fire, acc;
        b.req_valid = v;
        b.req_op    = 5'(op);
        b.req_dest  = 5'(d);
        b.req_src1  = 5'(s1);
        b.req_src2  = 5'(s2);
        b.req_imm   = 16'(imm);
        b.out_ready = ordy;
        #1;
        exp_rdy = (q.size() == 0) || (ordy && q.size() == 1);
        chk("req_ready", 32'(b.req_ready), 32'(exp_rdy));
        chk("req_ready_w", 32'(bw.req_ready), 32'(exp_rdy));
        chk("out_valid", 32'(b.out_valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
            chk("out_word", b.out_word, q[0]);
            chk("out_addr", 32'(b.out_addr), 32'(m_addr));
            chk("out_addr_w", 32'(bw.out_addr), 32'(m_addr % 4));
        end
        fire = (q.size() > 0) && ordy;
        acc  = v && exp_rdy;
        if (fire) begin
            void'(q.pop_front());
            m_hs++;
            m_addr = (m_addr + 1) % 1024;
        end
        if (acc) begin
            if (op <= 20) push_expected(op, d, s1, s2, imm);
            else m_err = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("err", 32'(err), 32'(m_err));
        chk("err_w", 32'(err_w), 32'(m_err));
        chk("wrapped", 32'(wrapped), 32'(m_hs >= 1024));
        chk("wrapped_w", 32'(wrapped_w), 32'(m_hs >= 4));
    endtask

    task automatic idle(input bit ordy);
        cycle(1'b0, 0, 0, 0, 0, 0, ordy);
    endtask

    task automatic do_reset();
        b.req_valid = 1'b0;
        b.out_ready = 1'b0;
        rst = 1'b1;
        #2;
        chk("rst_valid", 32'(b.out_valid), 32'h0);
        chk("rst_valid_w", 32'(bw.out_valid), 32'h0);
        chk("rst_word", b.out_word, 32'h0);
        chk("rst_addr", 32'(b.out_addr), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_wrapped", 32'(wrapped), 32'h0);
        chk("rst_ready", 32'(b.req_ready), 32'h1);
        q.delete();
        m_addr = 0;
        m_hs   = 0;
        m_err  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        b.req_valid = 1'b0;
        b.req_op    = '0;
        b.req_dest  = '0;
        b.req_src1  = '0;
        b.req_src2  = '0;
        b.req_imm   = '0;
        b.out_ready = 1'b0;
        #3;
        do_reset();

        // ADD d3 s1 s2
        cycle(1'b1, 1, 3, 1, 2, 0, 1'b1);
        chk("add_word", b.out_word, 32'h04611000);
        chk("add_addr", 32'(b.out_addr), 32'h0);
        idle(1'b1);

        // ADDI then NOP back to back
        do_reset();
        cycle(1'b1, 12, 5, 0, 0, 16'h00FF, 1'b1);
        chk("addi_word", b.out_word, 32'h80A000FF);
        cycle(1'b1, 0, 9, 9, 9, 16'h1234, 1'b1);
        chk("nop_word", b.out_word, 32'h0);
        chk("nop_addr", 32'(b.out_addr), 32'h1);
        idle(1'b1);

        // XSWP d1 s2; requests offered during expansion must be held off
        do_reset();
        cycle(1'b1, 20, 1, 2, 0, 0, 1'b1);
        chk("xswp_w0", b.out_word, 32'h20211000);
        cycle(1'b1, 1, 7, 7, 7, 0, 1'b1);
        chk("xswp_w1", b.out_word, 32'h20420800);
        cycle(1'b1, 1, 7, 7, 7, 0, 1'b1);
        chk("xswp_w2", b.out_word, 32'h20211000);
        chk("xswp_a2", 32'(b.out_addr), 32'h2);
        cycle(1'b1, 1, 7, 7, 7, 0, 1'b1);
        chk("after_xswp", b.out_word, 32'h04E73800);
        idle(1'b1);

        // Backpressure
        do_reset();
        cycle(1'b1, 1, 3, 1, 2, 0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 2, 4, 4, 4, 0, 1'b0);
            chk("stall_word", b.out_word, 32'h04611000);
            chk("stall_addr", 32'(b.out_addr), 32'h0);
        end
        idle(1'b1);
        cycle(1'b1, 2, 4, 4, 4, 0, 1'b1);
        chk("post_stall_addr", 32'(b.out_addr), 32'h1);
        idle(1'b1);

        // Unknown op then MOV
        do_reset();
        cycle(1'b1, 31, 1, 1, 1, 0, 1'b1);
        chk("unk_err", 32'(err), 32'h1);
        chk("unk_valid", 32'(b.out_valid), 32'h0);
        cycle(1'b1, 19, 4, 7, 3, 16'hBEEF, 1'b1);
        chk("mov_word", b.out_word, 32'h80870000);
        chk("mov_addr", 32'(b.out_addr), 32'h0);
        idle(1'b1);
        idle(1'b1);
        chk("err_sticky", 32'(err), 32'h1);

        // Unknown op accepted in HOLD drains to idle
        do_reset();
        cycle(1'b1, 1, 1, 1, 1, 0, 1'b1);
        cycle(1'b1, 25, 1, 1, 1, 0, 1'b1);
        chk("unk_hold_valid", 32'(b.out_valid), 32'h0);

        // Address wrap on the 2-bit twin, then reset mid-expansion
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, 1, i, 1, 1, 0, 1'b1);
        chk("wrap_addr_w", 32'(bw.out_addr), 32'h0);
        chk("wrap_flag_w", 32'(wrapped_w), 32'h1);
        idle(1'b1);
        cycle(1'b1, 20, 3, 5, 0, 0, 1'b1);
        idle(1'b1);
        do_reset();
        cycle(1'b1, 1, 3, 1, 2, 0, 1'b1);
        chk("post_rst_addr", 32'(b.out_addr), 32'h0);
        idle(1'b1);

        // Random traffic, long enough to wrap the 10-bit counter
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            int r;
            int op;
            r  = int'($urandom_range(0, 99));
            op = (r < 5) ? int'($urandom_range(21, 31)) : int'($urandom_range(0, 20));
            cycle(($urandom_range(0, 9) < 8), op,
                  int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                  int'($urandom_range(0, 31)), int'($urandom_range(0, 65535)),
                  ($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 4; i++) idle(1'b1);
        chk("drained", 32'(b.out_valid), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
